// File: rtl/ro_meter_pkg.sv
// Shared types and helpers for the multi-channel ring-oscillator frequency meter.
// Holds the FSM state encoding, mode constants and the channel-index width helper.
package ro_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    REPORT
  } state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CONT   = 1'b1;

  // Width of a channel index; never below 1 so a single-channel build still has a port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Per-channel synchroniser for an asynchronous oscillator input plus a
// rising-edge detector that compares the synchronised value with its previous sample.
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ro_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_multich_freq_meter.sv
// Multi-channel ring-oscillator frequency meter: counts synchronised rising edges of
// one channel at a time over a programmable gate, single-shot or round-robin.
module ro_multich_freq_meter
  import ro_meter_pkg::*;
#(
  parameter  int N_CH        = 4,
  parameter  int CNT_W       = 24,
  parameter  int GATE_W      = 20,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   ro_in,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [GATE_W-1:0] gate_cycles,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CNT_W-1:0]  result,
  output logic [CH_W-1:0]   result_ch,
  output logic              overflow
);

  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [GATE_W-1:0] SETTLE_LEN = GATE_W'(SYNC_STAGES);
  localparam logic [CH_W:0]     N_CH_V     = (CH_W + 1)'(N_CH);
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(N_CH - 1);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_ptr_q;
  logic [GATE_W-1:0] gate_len_q;
  logic [GATE_W-1:0] timer_q;
  logic [CNT_W-1:0]  count_q;
  logic              mode_q;
  logic              stop_seen_q;

  logic [N_CH-1:0]   edge_vec;
  logic              sel_edge;
  logic              start_ok;
  logic              timer_zero;
  logic              stop_now;
  logic [CNT_W-1:0]  count_nxt;

  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .reset      (reset),
      .ro_in      (ro_in[i]),
      .edge_pulse (edge_vec[i])
    );
  end

  assign sel_edge   = edge_vec[ch_ptr_q];
  assign start_ok   = start && ({1'b0, ch_sel} < N_CH_V);
  assign timer_zero = (timer_q == '0);
  assign stop_now   = stop || stop_seen_q;
  // The counter sticks at all-ones, so "count is at max" doubles as the overflow flag.
  assign count_nxt  = (sel_edge && count_q != CNT_MAX) ? count_q + CNT_W'(1) : count_q;

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == REPORT);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok)   state_d = SETTLE;
      SETTLE:  if (timer_zero) state_d = GATE;
      GATE:    if (timer_zero) state_d = REPORT;
      REPORT: begin
        if (result_ready) state_d = (mode_q == MODE_SINGLE || stop_now) ? IDLE : SETTLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_ptr_q    <= '0;
      gate_len_q  <= '0;
      timer_q     <= '0;
      count_q     <= '0;
      mode_q      <= MODE_SINGLE;
      stop_seen_q <= 1'b0;
      result      <= '0;
      result_ch   <= '0;
      overflow    <= 1'b0;
    end else begin
      stop_seen_q <= (state_q == IDLE) ? 1'b0 : (stop_seen_q | stop);
      unique case (state_q)
        IDLE: begin
          if (start_ok) begin
            ch_ptr_q   <= ch_sel;
            gate_len_q <= (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
            mode_q     <= mode;
            timer_q    <= SETTLE_LEN;
          end
        end
        SETTLE: begin
          count_q <= '0;
          timer_q <= timer_zero ? gate_len_q - GATE_W'(1) : timer_q - GATE_W'(1);
        end
        GATE: begin
          count_q <= count_nxt;
          timer_q <= timer_q - GATE_W'(1);
          if (timer_zero) begin
            result    <= count_nxt;
            result_ch <= ch_ptr_q;
            overflow  <= (count_nxt == CNT_MAX);
          end
        end
        REPORT: begin
          if (result_ready && mode_q == MODE_CONT && !stop_now) begin
            ch_ptr_q <= (ch_ptr_q == LAST_CH) ? '0 : ch_ptr_q + CH_W'(1);
            timer_q  <= SETTLE_LEN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_multich_freq_meter.sv
// Directed bench for ro_multich_freq_meter: table of single-shot measurements plus
// hand-written continuous-scan, backpressure, reset and invalid-channel sequences.
module tb_ro_multich_freq_meter;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 8;
  localparam int GATE_W = 20;
  localparam int SS     = 2;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N_CH-1:0]   ro_in = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              mode = 1'b0;
  logic [CH_W-1:0]   ch_sel = '0;
  logic [GATE_W-1:0] gate_cycles = '0;
  logic              busy, result_valid, overflow;
  logic              result_ready = 1'b0;
  logic [CNT_W-1:0]  result;
  logic [CH_W-1:0]   result_ch;

  // Five-channel instance: the only way to present an out-of-range ch_sel on the port.
  logic              start5 = 1'b0;
  logic [2:0]        ch_sel5 = 3'd7;
  logic              busy5, valid5, ovf5;
  logic [CNT_W-1:0]  result5;
  logic [2:0]        ch5;

  int checks = 0;
  int errors = 0;
  int per[N_CH];
  int ph[N_CH] = '{default: 0};

  typedef struct {
    int ch;
    int gate;
    int p0, p1, p2, p3;
    int exp;
    int tol;
    int ovf;
  } vec_t;

  vec_t vecs[7];

  ro_multich_freq_meter #(.N_CH(N_CH), .CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .ro_in(ro_in), .start(start), .stop(stop), .mode(mode),
    .ch_sel(ch_sel), .gate_cycles(gate_cycles), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .result_ch(result_ch), .overflow(overflow)
  );

  ro_multich_freq_meter #(.N_CH(5), .CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SS)) dut5 (
    .clk(clk), .reset(reset), .ro_in(5'b0), .start(start5), .stop(1'b0), .mode(1'b0),
    .ch_sel(ch_sel5), .gate_cycles('0), .busy(busy5), .result_valid(valid5),
    .result_ready(1'b1), .result(result5), .result_ch(ch5), .overflow(ovf5)
  );

  always #5 clk = ~clk;

  // Square waves of per[i] clk cycles, changed on the falling edge; period 0 holds low.
  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (per[i] == 0) begin
        ph[i]    = 0;
        ro_in[i] = 1'b0;
      end else begin
        ph[i]    = (ph[i] + 1) % per[i];
        ro_in[i] = (ph[i] < per[i] / 2);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_periods(input int p0, input int p1, input int p2, input int p3);
    per[0] = p0; per[1] = p1; per[2] = p2; per[3] = p3;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the start-sampling edge until result_valid is seen; -1 on timeout.
  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (result_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int g;
    g = (v.gate == 0) ? 1 : v.gate;
    mode         = 1'b0;
    stop         = 1'b0;
    result_ready = 1'b0;
    ch_sel       = CH_W'(v.ch);
    gate_cycles  = GATE_W'(v.gate);
    set_periods(v.p0, v.p1, v.p2, v.p3);
    repeat (4) tick();
    pulse_start();
    wait_valid(g + 50, lat);
    check({tag, " latency"}, lat, SS + 1 + g);
    check_near({tag, " result"}, int'(result), v.exp, v.tol);
    check({tag, " result_ch"}, 32'(result_ch), v.ch);
    check({tag, " overflow"}, 32'(overflow), v.ovf);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, " idle after handshake"}, 32'(busy), 0);
  endtask

  initial begin
    int lat, got, since4, bad, seen;
    int rch[5];
    int rres[5];
    int exp_ch[5]  = '{3, 0, 1, 2, 3};
    int exp_res[5] = '{20, 50, 40, 25, 20};
    logic [CNT_W-1:0] snap_res;
    logic [CH_W-1:0]  snap_ch;

    //        ch gate  p0   p1 p2  p3  exp tol ovf
    vecs[0] = '{0,    0, 0,  4, 4,  4,   0, 0, 0};
    vecs[1] = '{0,  200, 4,  5, 8, 10,  50, 1, 0};
    vecs[2] = '{1,  200, 4,  5, 8, 10,  40, 1, 0};
    vecs[3] = '{3,  200, 4,  5, 8, 10,  20, 1, 0};
    vecs[4] = '{0, 2000, 4,  4, 4,  4, 255, 0, 1};
    vecs[5] = '{0, 2000, 100, 4, 4, 4,  20, 1, 0};
    vecs[6] = '{2, 1000, 4,  4, 10, 4, 100, 1, 0};
    set_periods(4, 5, 8, 10);

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("reset busy", 32'(busy), 0);
    check("reset result_valid", 32'(result_valid), 0);
    check("reset result", 32'(result), 0);
    check("reset result_ch", 32'(result_ch), 0);
    check("reset overflow", 32'(overflow), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Continuous round-robin from channel 3; stop pulsed once during the 5th gate.
    set_periods(4, 5, 8, 10);
    mode = 1'b1; ch_sel = 2'd3; gate_cycles = 20'd200; result_ready = 1'b1; stop = 1'b0;
    repeat (4) tick();
    pulse_start();
    got = 0;
    since4 = 0;
    for (int i = 0; i < 3000 && got < 5; i++) begin
      tick();
      stop = 1'b0;
      if (got == 4) begin
        since4++;
        if (since4 == 20) stop = 1'b1;
      end
      if (result_valid) begin
        rch[got]  = int'(result_ch);
        rres[got] = int'(result);
        got++;
      end
    end
    stop = 1'b0;
    check("cont result count", got, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("cont ch[%0d]", i), rch[i], exp_ch[i]);
      check_near($sformatf("cont res[%0d]", i), rres[i], exp_res[i], 1);
    end
    tick();
    check("cont idle after stop", 32'(busy), 0);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (result_valid) seen++;
    end
    check("cont no result after stop", seen, 0);
    result_ready = 1'b0;

    // Backpressure: result held for 50 cycles while start/config are poked.
    mode = 1'b1; ch_sel = 2'd1; gate_cycles = 20'd100;
    repeat (4) tick();
    pulse_start();
    wait_valid(200, lat);
    check("bp latency", lat, SS + 1 + 100);
    snap_res = result;
    snap_ch  = result_ch;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      start = (i % 10 == 0);
      ch_sel = 2'd0;
      gate_cycles = 20'd7;
      tick();
      if (!result_valid || !busy || result !== snap_res || result_ch !== snap_ch) bad++;
    end
    start = 1'b0;
    check("bp stable cycles with errors", bad, 0);
    check_near("bp result", int'(result), 20, 1);
    check("bp result_ch", 32'(result_ch), 1);
    stop = 1'b1; result_ready = 1'b1;
    tick();
    stop = 1'b0; result_ready = 1'b0;
    check("bp idle after handshake", 32'(busy), 0);
    check("bp valid dropped", 32'(result_valid), 0);

    // Reset mid-gate aborts without a result.
    mode = 1'b0; ch_sel = 2'd1; gate_cycles = 20'd1000;
    repeat (4) tick();
    pulse_start();
    repeat (500) tick();
    check("mid-gate busy", 32'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst busy", 32'(busy), 0);
    check("rst result_valid", 32'(result_valid), 0);
    check("rst result", 32'(result), 0);
    check("rst result_ch", 32'(result_ch), 0);
    check("rst overflow", 32'(overflow), 0);
    seen = 0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (result_valid) seen++;
    end
    check("rst no result", seen, 0);
    run_vec(vecs[2], "post-reset");

    // Out-of-range channel select on the five-channel instance.
    ch_sel5 = 3'd5;
    start5 = 1'b1; tick(); start5 = 1'b0;
    repeat (3) tick();
    check("ch_sel=5 ignored", 32'(busy5), 0);
    ch_sel5 = 3'd7;
    start5 = 1'b1; tick(); start5 = 1'b0;
    repeat (3) tick();
    check("ch_sel=7 ignored", 32'(busy5), 0);
    ch_sel5 = 3'd4;
    start5 = 1'b1; tick(); start5 = 1'b0;
    check("ch_sel=4 accepted", 32'(busy5), 1);
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      tick();
      if (valid5) seen = 1;
    end
    check("ch4 result valid", seen, 1);
    check("ch4 result_ch", 32'(ch5), 4);
    check("ch4 result", 32'(result5), 0);
    check("ch4 overflow", 32'(ovf5), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
